// File: rtl/adc_capture_buffer.sv
// Trigger-armed snapshot buffer for the AD9284 IDDR sample pair with valid/ready readout.
// Optional build macro ADC_CAPTURE_RAMP_EN adds ramp_sel and an internal test ramp source.
module adc_capture_buffer #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 10,
    parameter int PRE_DEPTH = 256
) (
    input  logic                adc_dco_clk,
    input  logic                reset_n,
    input  logic [DATA_W-1:0]   adc_data_p,
    input  logic [DATA_W-1:0]   adc_data_n,
`ifdef ADC_CAPTURE_RAMP_EN
    input  logic                ramp_sel,
`endif
    input  logic                arm,
    input  logic                abort,
    input  logic [DATA_W-1:0]   trig_level,
    input  logic                trig_force,
    output logic                armed,
    output logic                triggered,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [2*DATA_W-1:0] rd_data,
    output logic                rd_last
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = ADDR_W + 1;

    localparam logic [CW-1:0]     POST_INIT = CW'(DEPTH - PRE_DEPTH - 1);
    localparam logic [CW-1:0]     PRE_LAST  = CW'(PRE_DEPTH - 1);
    localparam logic [CW-1:0]     DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0]     ISS_LAST  = CW'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PRE_OFF   = ADDR_W'(PRE_DEPTH);

    typedef enum logic [2:0] {IDLE, PREFILL, WAIT_TRIG, POST, READ} state_t;

    typedef struct packed {
        logic                last;
        logic [2*DATA_W-1:0] data;
    } rd_word_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   src_p, src_n;
    logic [DATA_W-1:0]   s_p, s_n, prev_p;
    logic [ADDR_W-1:0]   wp, rp;
    logic [CW-1:0]       pre_cnt, post_cnt, iss_cnt;
    logic                trig_hit, wr_en, rd_en, pop;
    logic [1:0]          occ;
    logic [2*DATA_W-1:0] mem [DEPTH];
    logic [2*DATA_W-1:0] ram_q;
    logic                ram_vld, ram_last;
    rd_word_t            ram_w, out_q, sk_q;
    logic                sk_valid;

    // ------------------------------------------------------------------
    // Input source and register stage
    // ------------------------------------------------------------------
`ifdef ADC_CAPTURE_RAMP_EN
    logic [7:0] ramp;

    always_ff @(posedge adc_dco_clk) begin
        if (!reset_n) ramp <= '0;
        else          ramp <= ramp + 8'd1;
    end

    always_comb begin
        src_p = adc_data_p;
        src_n = adc_data_n;
        if (ramp_sel) begin
            src_p = DATA_W'(ramp);
            src_n = ~DATA_W'(ramp);
        end
    end
`else
    assign src_p = adc_data_p;
    assign src_n = adc_data_n;
`endif

    always_ff @(posedge adc_dco_clk) begin
        if (!reset_n) begin
            s_p    <= '0;
            s_n    <= '0;
            prev_p <= '0;
        end else begin
            s_p    <= src_p;
            s_n    <= src_n;
            prev_p <= s_p;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    assign trig_hit = ((prev_p < trig_level) && (s_p >= trig_level)) || trig_force;
    assign pop      = rd_valid && rd_ready;
    assign wr_en    = (state == PREFILL) || (state == WAIT_TRIG) || (state == POST);
    assign armed    = (state == PREFILL) || (state == WAIT_TRIG);
    assign triggered = (state == POST) || (state == READ);

    always_ff @(posedge adc_dco_clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (arm) state_nxt = PREFILL;
            PREFILL:   if (pre_cnt == PRE_LAST) state_nxt = WAIT_TRIG;
            WAIT_TRIG: if (trig_hit) state_nxt = (POST_INIT == '0) ? READ : POST;
            POST:      if (post_cnt == CW'(1)) state_nxt = READ;
            READ:      if (pop && out_q.last) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // ------------------------------------------------------------------
    // Pointers and counters
    // ------------------------------------------------------------------
    // The read start is taken from wp at the trigger word, so no separate
    // trigger-address register is kept.
    always_ff @(posedge adc_dco_clk) begin
        if (!reset_n || abort) begin
            wp       <= '0;
            rp       <= '0;
            pre_cnt  <= '0;
            post_cnt <= '0;
            iss_cnt  <= '0;
        end else begin
            case (state)
                IDLE: if (arm) begin
                    wp      <= '0;
                    pre_cnt <= '0;
                end
                PREFILL: begin
                    wp      <= wp + 1'b1;
                    pre_cnt <= pre_cnt + 1'b1;
                end
                WAIT_TRIG: begin
                    wp <= wp + 1'b1;
                    if (trig_hit) begin
                        post_cnt <= POST_INIT;
                        rp       <= wp - PRE_OFF;
                        iss_cnt  <= '0;
                    end
                end
                POST: begin
                    wp       <= wp + 1'b1;
                    post_cnt <= post_cnt - 1'b1;
                end
                READ: if (rd_en) begin
                    rp      <= rp + 1'b1;
                    iss_cnt <= iss_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sample RAM: 1-cycle registered read, never read and written together
    // ------------------------------------------------------------------
    always_ff @(posedge adc_dco_clk) begin
        if (wr_en) mem[wp] <= {s_n, s_p};
        if (rd_en) ram_q   <= mem[rp];
    end

    // Credit over RAM-in-flight + output reg + skid keeps at most two words
    // outstanding, which is enough for one word per cycle with ready high.
    assign occ   = 2'(rd_valid) + 2'(sk_valid) + 2'(ram_vld);
    assign rd_en = (state == READ) && (iss_cnt < DEPTH_C) && ((occ - 2'(pop)) < 2'd2);
    assign ram_w = '{last: ram_last, data: ram_q};

    // ------------------------------------------------------------------
    // Output register with skid
    // ------------------------------------------------------------------
    always_ff @(posedge adc_dco_clk) begin
        if (!reset_n || abort) begin
            ram_vld  <= 1'b0;
            ram_last <= 1'b0;
            rd_valid <= 1'b0;
            out_q    <= '0;
            sk_valid <= 1'b0;
            sk_q     <= '0;
        end else begin
            ram_vld  <= rd_en;
            ram_last <= rd_en && (iss_cnt == ISS_LAST);
            if (!rd_valid || pop) begin
                if (sk_valid) begin
                    out_q    <= sk_q;
                    rd_valid <= 1'b1;
                    sk_valid <= ram_vld;
                    if (ram_vld) sk_q <= ram_w;
                end else if (ram_vld) begin
                    out_q    <= ram_w;
                    rd_valid <= 1'b1;
                end else begin
                    rd_valid   <= 1'b0;
                    out_q.last <= 1'b0;
                end
            end else if (ram_vld) begin
                sk_q     <= ram_w;
                sk_valid <= 1'b1;
            end
        end
    end

    assign rd_data = out_q.data;
    assign rd_last = out_q.last;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Randomized self-checking bench: expected windows come from a sample-stream model
// (first qualifying crossing/force after the pre-trigger fill, then a slice of the stream).
module tb_adc_capture_buffer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int PRE    = 4;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NS     = 128;

    logic        clk = 1'b0;
    logic        reset_n, arm, abort, trig_force, rd_ready;
    logic [7:0]  adc_data_p, adc_data_n, trig_level;
    logic        armed, triggered, rd_valid, rd_last;
    logic [15:0] rd_data;
`ifdef ADC_CAPTURE_RAMP_EN
    logic        ramp_sel;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  xp [NS];
    logic [7:0]  xn [NS];
    bit          xf [NS];
    int          T;
    logic [15:0] exp_win [DEPTH];

    always #5 clk = ~clk;

    adc_capture_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PRE_DEPTH(PRE)) dut (
        .adc_dco_clk (clk),
        .reset_n     (reset_n),
        .adc_data_p  (adc_data_p),
        .adc_data_n  (adc_data_n),
`ifdef ADC_CAPTURE_RAMP_EN
        .ramp_sel    (ramp_sel),
`endif
        .arm         (arm),
        .abort       (abort),
        .trig_level  (trig_level),
        .trig_force  (trig_force),
        .armed       (armed),
        .triggered   (triggered),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_last     (rd_last)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stream index k = k-th registered sample after arm; pins for k are driven
    // in loop cycle k, trig_force for k in loop cycle k+1.
    task automatic gen(input int mode);
        for (int k = 0; k < NS; k++) begin
            xn[k] = 8'($urandom);
            xf[k] = 1'b0;
            case (mode)
                0: xp[k] = 8'(k);
                1: xp[k] = 8'h50;
                2: xp[k] = (k == 1) ? 8'h50 : (k >= 9) ? 8'h60 : 8'h10;
                default: xp[k] = 8'($urandom);
            endcase
        end
        if (mode == 1) xf[20] = 1'b1;
        if (mode == 3) xf[40] = 1'b1;
    endtask

    function automatic void build_model(input logic [7:0] lvl);
        T = -1;
        for (int k = PRE; k < NS; k++)
            if (T < 0 && ((xp[k-1] < lvl && xp[k] >= lvl) || xf[k])) T = k;
        for (int i = 0; i < DEPTH; i++)
            exp_win[i] = (T >= 0) ? {xn[T-PRE+i], xp[T-PRE+i]} : 16'h0;
    endfunction

    // stop_mode: 0 full capture, 1 abort during POST, 2 reset at first rd_valid
    task automatic run_capture(input logic [7:0] lvl, input bit rnd_rdy,
                               input int stop_mode, input bit ramp_mode);
        logic [15:0] rx [DEPTH];
        logic [15:0] held;
        logic        held_last;
        logic [7:0]  rp8;
        bit          stall, done;
        int          nrx, first_v, last_v;
        trig_level = lvl;
        if (!ramp_mode) begin
            build_model(lvl);
            chk("model_trig_found", 32'(T >= 0), 32'd1);
        end
        nrx = 0; stall = 0; done = 0; first_v = -1; last_v = -1;
        held = '0; held_last = 1'b0;
        for (int k = 0; k < 800; k++) begin
            if (!ramp_mode && !done) begin
                chk("armed", 32'(armed), 32'(k >= 1 && k <= T + 1));
                chk("triggered", 32'(triggered), 32'(k >= T + 2));
            end
            if (stall) begin
                chk("stall_valid", 32'(rd_valid), 32'd1);
                chk("stall_data", 32'(rd_data), 32'(held));
                chk("stall_last", 32'(rd_last), 32'(held_last));
            end
            if (done) begin
                chk("idle_armed", 32'(armed), 32'd0);
                chk("idle_triggered", 32'(triggered), 32'd0);
                chk("idle_valid", 32'(rd_valid), 32'd0);
                break;
            end
            if (stop_mode == 1 && k == T + 4) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                chk("abort_armed", 32'(armed), 32'd0);
                chk("abort_triggered", 32'(triggered), 32'd0);
                chk("abort_valid", 32'(rd_valid), 32'd0);
                return;
            end
            if (stop_mode == 2 && rd_valid) begin
                rd_ready = 1'b0;
                reset_n  = 1'b0;
                @(posedge clk); #1;
                reset_n  = 1'b1;
                chk("rst_armed", 32'(armed), 32'd0);
                chk("rst_triggered", 32'(triggered), 32'd0);
                chk("rst_valid", 32'(rd_valid), 32'd0);
                chk("rst_last", 32'(rd_last), 32'd0);
                chk("rst_data", 32'(rd_data), 32'd0);
                return;
            end
            arm        = (k == 0);
            adc_data_p = (k < NS) ? xp[k] : 8'($urandom);
            adc_data_n = (k < NS) ? xn[k] : 8'($urandom);
            trig_force = (!ramp_mode && k >= 1 && k <= NS) ? xf[k-1] : 1'b0;
            rd_ready   = rnd_rdy ? 1'($urandom) : 1'b1;
            if (rd_valid && rd_ready) begin
                if (first_v < 0) first_v = k;
                last_v = k;
                rx[nrx] = rd_data;
                chk("rd_last", 32'(rd_last), 32'(nrx == DEPTH - 1));
                nrx++;
                if (nrx == DEPTH) done = 1'b1;
            end
            stall     = rd_valid && !rd_ready;
            held      = rd_data;
            held_last = rd_last;
            @(posedge clk); #1;
        end
        arm = 1'b0; trig_force = 1'b0;
        chk("rx_count", 32'(nrx), 32'(DEPTH));
        for (int i = 0; i < nrx; i++) begin
            if (ramp_mode) begin
                rp8 = 8'h80 + 8'(i) - 8'(PRE);
                chk("ramp_word", 32'(rx[i]), 32'({~rp8, rp8}));
            end else begin
                chk("win_word", 32'(rx[i]), 32'(exp_win[i]));
            end
        end
        if (!rnd_rdy && !ramp_mode && nrx == DEPTH) begin
            chk("first_valid_latency", 32'(first_v <= T + 1 + (DEPTH - PRE) + 2), 32'd1);
            chk("burst_cycles", 32'(last_v - first_v), 32'(DEPTH - 1));
        end
    endtask

    initial begin
        reset_n = 1'b0; arm = 1'b0; abort = 1'b0; trig_force = 1'b0; rd_ready = 1'b0;
        adc_data_p = '0; adc_data_n = '0; trig_level = '0;
`ifdef ADC_CAPTURE_RAMP_EN
        ramp_sel = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_armed", 32'(armed), 32'd0);
        chk("reset_triggered", 32'(triggered), 32'd0);
        chk("reset_valid", 32'(rd_valid), 32'd0);
        chk("reset_last", 32'(rd_last), 32'd0);
        chk("reset_data", 32'(rd_data), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        gen(0); run_capture(8'h40, 1'b0, 0, 1'b0);   // level trigger on ramp
        gen(1); run_capture(8'h40, 1'b0, 0, 1'b0);   // forced trigger, flat data
        gen(0); run_capture(8'h40, 1'b1, 0, 1'b0);   // back-pressure
        gen(2); run_capture(8'h40, 1'b1, 0, 1'b0);   // crossing inside prefill ignored
        gen(0); run_capture(8'h40, 1'b0, 1, 1'b0);   // abort in POST
        gen(0); run_capture(8'h40, 1'b0, 2, 1'b0);   // reset mid-read
        gen(0); run_capture(8'h40, 1'b0, 0, 1'b0);   // clean capture afterwards
        repeat (4) begin
            gen(3);
            run_capture(8'($urandom_range(8'h20, 8'hE0)), 1'b1, 0, 1'b0);
        end
`ifdef ADC_CAPTURE_RAMP_EN
        ramp_sel = 1'b1;
        run_capture(8'h80, 1'b1, 0, 1'b1);
        ramp_sel = 1'b0;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adc_capture_buffer.md
# adc_capture_buffer

Trigger-armed snapshot buffer directly downstream of the AD9284 LVDS/IDDR capture stage. Takes the rising-edge (`Q1`) and falling-edge (`Q2`) 8-bit sample pair delivered every `adc_dco_clk` cycle and stores a fixed-length window around a level-crossing trigger, with a programmable pre-trigger history. The stored window is then streamed out over a valid/ready port in the same clock domain for LED/debug/host readout.

## Interface
- `DATA_W`, 8, width of each IDDR sample (p and n).
- `ADDR_W`, 10, buffer address width; depth `DEPTH = 2**ADDR_W` words of `2*DATA_W` bits.
- `PRE_DEPTH`, 256, words kept before the trigger word; legal range 1 to `DEPTH-1`.

- `adc_dco_clk` in 1: ADC DCO clock after BUFR; the only clock.
- `reset_n` in 1: synchronous, active-low reset.
- `adc_data_p` in `DATA_W`: IDDR Q1 sample (channel A).
- `adc_data_n` in `DATA_W`: IDDR Q2 sample (channel B).
- `arm` in 1: single-cycle request to start a capture; honoured only in IDLE.
- `abort` in 1: return to IDLE from any state.
- `trig_level` in `DATA_W`: unsigned threshold on channel A.
- `trig_force` in 1: immediate trigger while waiting.
- `armed` out 1: high in PREFILL and WAIT_TRIG.
- `triggered` out 1: high in POST and READ.
- `rd_valid` out 1: readout word valid.
- `rd_ready` in 1: consumer accepts word.
- `rd_data` out `2*DATA_W`: `{n, p}` sample pair.
- `rd_last` out 1: final word of window, qualified by `rd_valid`.

## Operation
- Input register stage: `adc_data_p`/`adc_data_n` registered every cycle into `s_p`/`s_n`; `prev_p` holds the previous `s_p`. All writes and trigger checks use the registered values.
- States: IDLE, PREFILL, WAIT_TRIG, POST, READ.
- IDLE: no writes. `arm=1` clears the write pointer `wp` to 0 and moves to PREFILL.
- PREFILL: write `{s_n,s_p}` at `wp` every cycle, then `wp++`. After `PRE_DEPTH` writes, move to WAIT_TRIG. Triggers are ignored in this state.
- WAIT_TRIG: keep writing circularly; `wp` wraps from `DEPTH-1` to 0.
  - Trigger condition: `(prev_p < trig_level && s_p >= trig_level)`, unsigned, or `trig_force`. Both together count as one trigger.
  - On trigger, the current word is written at `wp` and `trig_addr = wp` is latched. The FSM moves to POST with `post_cnt = DEPTH-PRE_DEPTH-1`.
- POST: write and decrement `post_cnt`. When `post_cnt` reaches 0 after a write, move to READ. If `DEPTH-PRE_DEPTH-1 = 0`, go straight to READ.
- READ: read pointer starts at `trig_addr - PRE_DEPTH` mod `DEPTH`. Exactly `DEPTH` words are emitted in address order with wrap, so the trigger word is word index `PRE_DEPTH`. `rd_last` is set on word `DEPTH-1`. The handshake that accepts the last word returns the FSM to IDLE.
- Handshake: a word transfers when `rd_valid && rd_ready`. While `rd_valid && !rd_ready`, `rd_data` and `rd_last` hold stable. `rd_valid` never depends combinationally on `rd_ready`.
- `abort` has priority over `arm` and over every transition. It takes effect next cycle: state IDLE, `rd_valid`=0, counters cleared, buffer contents don't-care.
- `arm` outside IDLE is ignored. `arm` together with `abort` resolves to IDLE.

## Timing
- Reset (`reset_n=0` at a clock edge) gives: state IDLE; `armed`, `triggered`, `rd_valid`, `rd_last` = 0; `rd_data` = 0; `wp`, read pointer, counters = 0; `s_p`, `s_n`, `prev_p` = 0. Reset mid-capture or mid-read behaves identically.
- Pipeline: pins at cycle t → `s_*` at t+1 → RAM write and trigger evaluation in cycle t+1.
- `armed` rises the cycle after `arm` is sampled.
- The first PREFILL write is the sample registered in the first PREFILL cycle.
- Simple dual-port RAM with 1-cycle read latency, plus one output skid register.
  - First `rd_valid` comes no later than 2 cycles after entering READ.
  - With `rd_ready` held high, throughput is 1 word/cycle and all `DEPTH` words are delivered in `DEPTH` consecutive cycles after the first.
- `triggered` rises the cycle after the trigger cycle and falls the cycle after the last handshake.

## Configuration
- `ADC_CAPTURE_RAMP_EN` defined: adds input port `ramp_sel` (1 bit). An internal 8-bit counter `ramp` resets to 0 and increments every cycle.
  - When `ramp_sel=1`, the input register loads `p = ramp`, `n = ~ramp` instead of the pins.
  - Trigger logic runs on the substituted data.
- Not defined: port absent and pin data always used.

## Test plan
- `ADDR_W=4`, `PRE_DEPTH=4`, ramp p=0,1,2,…, `trig_level=8'h40`, `arm` → WAIT_TRIG, trigger at registered p=0x40. Readout gives 16 words with p = 0x3C…0x4B; `rd_last` on p=0x4B; state returns to IDLE.
- Same setup, hold p=0x50 constant and pulse `trig_force` after 20 cycles → trigger word (index 4) is the forced sample. No level trigger occurs, because there is no crossing.
- Random `rd_ready` (50% duty) during READ → exactly 16 transfers. `rd_data` is stable across every stalled cycle. The sequence matches the `rd_ready`=1 run.
- p crosses 0x40 during PREFILL → no trigger. The first crossing after PREFILL completes triggers.
- `abort` during POST, then `reset_n=0` during READ with `rd_valid` high → IDLE next cycle, all outputs 0. A following `arm` captures correctly.
- With `ADC_CAPTURE_RAMP_EN` and `ramp_sel=1`, `trig_level=8'h80` → trigger word is `{8'h7F, 8'h80}` (n=~p), at index `PRE_DEPTH`.
